// File: rtl/cpu_pkg.sv
// Shared CPU fetch types: default bus widths, halt encoding and the buffered fetch entry.
package cpu_pkg;
    localparam int CPU_ADDR_W = 11;
    localparam int CPU_DATA_W = 16;
    localparam logic [CPU_DATA_W-1:0] HALT_OPCODE = 16'h00FF;

    typedef struct packed {
        logic [CPU_DATA_W-1:0] data;
        logic [CPU_ADDR_W-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/prom_fetch_if.sv
// pROM read port, jump redirect and instruction handshake of the fetch front-end.
interface prom_fetch_if #(
    parameter int ADDR_W = cpu_pkg::CPU_ADDR_W,
    parameter int DATA_W = cpu_pkg::CPU_DATA_W
);
    logic [ADDR_W-1:0] prom_ad;
    logic              prom_ce;
    logic              prom_oce;
    logic [DATA_W-1:0] prom_dout;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_addr;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              halted;

    modport master (
        output prom_ad, prom_ce, prom_oce, instr_valid, instr_data, instr_pc, halted,
        input  prom_dout, jump_valid, jump_addr, instr_ready
    );

    modport slave (
        input  prom_ad, prom_ce, prom_oce, instr_valid, instr_data, instr_pc, halted,
        output prom_dout, jump_valid, jump_addr, instr_ready
    );
endinterface

// File: rtl/fetch_fifo2.sv
// 2-entry registered FIFO of {data, pc}; head is always entry 0, so the output is a plain register.
// Latency: push visible at the head the next cycle. Backpressure: caller must not push when full.
module fetch_fifo2
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_dat_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_dat_o,
    output logic [1:0]   count_o
);
    fetch_entry_t e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = push_dat_i;
                    else               e1_d = push_dat_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    if (cnt_q == 2'd2) e0_d = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = push_dat_i;
                    end else begin
                        e0_d = push_dat_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_dat_o = e0_q;
    assign count_o    = cnt_q;
endmodule

// File: rtl/prom_fetch.sv
// Instruction fetch front-end for the pROM; optional halt-on-opcode stop under FETCH_HALT_EN.
// Latency: prom_ce at N -> instr_valid at N+2; jump at J -> target valid at J+3.
// Backpressure: issue only while buffered + in-flight stays below 2, so instr_ready low stalls prom_ce.
module prom_fetch #(
    parameter int                 ADDR_W      = cpu_pkg::CPU_ADDR_W,
    parameter int                 DATA_W      = cpu_pkg::CPU_DATA_W,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [DATA_W-1:0]  HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic          clk,
    input  logic          rst_n,
    prom_fetch_if.master  bus
);
    import cpu_pkg::*;

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              kill_q, kill_d;
    logic              halted_q, halted_d;

    logic [1:0]        count;
    fetch_entry_t      head, push_ent;
    logic              pop, push, flush, issue, halt_hit;
    logic [2:0]        occ;

    assign pop = (count != 2'd0) && bus.instr_ready;

`ifdef FETCH_HALT_EN
    assign halt_hit = pop && (head.data == HALT_OPCODE);
`else
    assign halt_hit = 1'b0;
`endif

    assign occ   = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    // rst_n gates issue so prom_ce is low for the whole reset interval
    assign issue = rst_n && !halted_q && !halt_hit && !bus.jump_valid && (occ < 3'd2);
    assign flush = bus.jump_valid || halt_hit;
    assign push  = inflight_q && !kill_q && !flush;

    assign push_ent.data = bus.prom_dout;
    assign push_ent.pc   = inflight_pc_q;

    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        kill_d        = 1'b0;
        halted_d      = halted_q;
        if (issue) begin
            fpc_d         = fpc_q + 1'b1;
            inflight_pc_d = fpc_q;
        end
        if (bus.jump_valid) begin
            fpc_d    = bus.jump_addr;
            kill_d   = inflight_q;
            halted_d = 1'b0;
        end else if (halt_hit) begin
            kill_d   = inflight_q;
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q         <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
            halted_q      <= halted_d;
        end
    end

    fetch_fifo2 u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .flush_i    (flush),
        .head_dat_o (head),
        .count_o    (count)
    );

    assign bus.prom_ad     = fpc_q;
    assign bus.prom_ce     = issue;
    assign bus.prom_oce    = 1'b1;
    assign bus.instr_valid = (count != 2'd0);
    assign bus.instr_data  = head.data;
    assign bus.instr_pc    = head.pc;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_prom_fetch.sv
// Directed bench for prom_fetch with a behavioural one-cycle-latency pROM model.
module tb_prom_fetch;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [15:0] mem [0:2047];

    prom_fetch_if #(.ADDR_W(11), .DATA_W(16)) bus ();

    prom_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.prom_ce) bus.prom_dout <= mem[bus.prom_ad];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [10:0] pc, input logic [15:0] data);
        chk({tag, "_vld"}, 32'(bus.instr_valid), 32'h1);
        chk({tag, "_pc"}, 32'(bus.instr_pc), 32'(pc));
        chk({tag, "_dat"}, 32'(bus.instr_data), 32'(data));
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus.jump_valid  = 1'b0;
        bus.jump_addr   = '0;
        bus.instr_ready = 1'b1;
        bus.prom_dout   = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'hA000 ^ 16'(i);
        mem[0] = 16'h78A1;
        mem[1] = 16'h9166;
        mem[2] = 16'h0000;
        mem[3] = 16'h0000;

        // reset values
        cyc(); #1;
        chk("rst_ce",    32'(bus.prom_ce),     32'h0);
        chk("rst_ad",    32'(bus.prom_ad),     32'h0);
        chk("rst_oce",   32'(bus.prom_oce),    32'h1);
        chk("rst_vld",   32'(bus.instr_valid), 32'h0);
        chk("rst_dat",   32'(bus.instr_data),  32'h0);
        chk("rst_pc",    32'(bus.instr_pc),    32'h0);
        chk("rst_halt",  32'(bus.halted),      32'h0);

        // release: cycle 0 issues pc 0, stream from cycle 2
        rst_n = 1'b1; #1;
        chk("c0_ce", 32'(bus.prom_ce), 32'h1);
        chk("c0_ad", 32'(bus.prom_ad), 32'h0);
        cyc(); #1;
        chk("c1_vld", 32'(bus.instr_valid), 32'h0);
        chk("c1_ad",  32'(bus.prom_ad),     32'h1);
        cyc(); #1; chk_out("c2", 11'h000, 16'h78A1);
        cyc(); #1; chk_out("c3", 11'h001, 16'h9166);
        cyc(); #1; chk_out("c4", 11'h002, 16'h0000);
        cyc(); #1; chk_out("c5", 11'h003, 16'h0000);
        cyc(); #1; chk_out("c6", 11'h004, 16'hA004);

        // backpressure after the first valid
        rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc();
        cyc(); bus.instr_ready = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            chk_out("bp", 11'h000, 16'h78A1);
            chk("bp_ce", 32'(bus.prom_ce), 32'h0);
            cyc();
        end
        bus.instr_ready = 1'b1; #1;
        chk_out("bp_r0", 11'h000, 16'h78A1);
        chk("bp_r0_ce", 32'(bus.prom_ce), 32'h1);
        chk("bp_r0_ad", 32'(bus.prom_ad), 32'h2);
        cyc(); #1; chk_out("bp_r1", 11'h001, 16'h9166);
        cyc(); #1; chk_out("bp_r2", 11'h002, 16'h0000);

        // jump with a fetch in flight: pop of pc 3 completes, pc 4 never appears
        cyc(); bus.jump_valid = 1'b1; bus.jump_addr = 11'h100; #1;
        chk_out("j_pop", 11'h003, 16'h0000);
        chk("j_ce", 32'(bus.prom_ce), 32'h0);
        cyc(); bus.jump_valid = 1'b0; #1;
        chk("j1_vld", 32'(bus.instr_valid), 32'h0);
        chk("j1_ce",  32'(bus.prom_ce),     32'h1);
        chk("j1_ad",  32'(bus.prom_ad),     32'h100);
        cyc(); #1; chk("j2_vld", 32'(bus.instr_valid), 32'h0);
        cyc(); #1; chk_out("j3", 11'h100, 16'hA100);
        cyc(); #1; chk_out("j4", 11'h101, 16'hA101);

        // stall until the FIFO is full, then jump to the top of memory and wrap
        cyc(); bus.instr_ready = 1'b0; #1;
        chk_out("w_st", 11'h102, 16'hA102);
        cyc(); bus.jump_valid = 1'b1; bus.jump_addr = 11'h7FE; #1;
        chk_out("w_full", 11'h102, 16'hA102);
        cyc(); bus.jump_valid = 1'b0; bus.instr_ready = 1'b1; #1;
        chk("w1_vld", 32'(bus.instr_valid), 32'h0);
        chk("w1_ad",  32'(bus.prom_ad),     32'h7FE);
        cyc(); #1; chk("w2_vld", 32'(bus.instr_valid), 32'h0);
        cyc(); #1; chk_out("w3", 11'h7FE, 16'hA7FE);
        cyc(); #1; chk_out("w4", 11'h7FF, 16'hA7FF);
        cyc(); #1; chk_out("w5", 11'h000, 16'h78A1);

        // asynchronous reset pulse while streaming
        cyc(); rst_n = 1'b0; #1;
        chk("ar_vld", 32'(bus.instr_valid), 32'h0);
        chk("ar_dat", 32'(bus.instr_data),  32'h0);
        chk("ar_pc",  32'(bus.instr_pc),    32'h0);
        chk("ar_ce",  32'(bus.prom_ce),     32'h0);
        chk("ar_ad",  32'(bus.prom_ad),     32'h0);
        cyc(); rst_n = 1'b1; #1;
        chk("ar0_ce", 32'(bus.prom_ce), 32'h1);
        chk("ar0_ad", 32'(bus.prom_ad), 32'h0);
        cyc(); #1; chk("ar1_vld", 32'(bus.instr_valid), 32'h0);
        cyc(); #1; chk_out("ar2", 11'h000, 16'h78A1);
        cyc(); #1; chk_out("ar3", 11'h001, 16'h9166);

`ifdef FETCH_HALT_EN
        // halt on pc 2, resume with a jump to 0
        mem[2] = 16'h00FF;
        rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc();
        cyc(); #1; chk_out("h2", 11'h000, 16'h78A1);
        cyc(); #1; chk_out("h3", 11'h001, 16'h9166);
        cyc(); #1; chk_out("h4", 11'h002, 16'h00FF);
        chk("h4_ce", 32'(bus.prom_ce), 32'h0);
        cyc(); #1;
        chk("h5_halt", 32'(bus.halted),      32'h1);
        chk("h5_vld",  32'(bus.instr_valid), 32'h0);
        chk("h5_ce",   32'(bus.prom_ce),     32'h0);
        cyc(); bus.jump_valid = 1'b1; bus.jump_addr = 11'h000; #1;
        chk("h6_halt", 32'(bus.halted), 32'h1);
        cyc(); bus.jump_valid = 1'b0; #1;
        chk("h7_halt", 32'(bus.halted),  32'h0);
        chk("h7_ce",   32'(bus.prom_ce), 32'h1);
        chk("h7_ad",   32'(bus.prom_ad), 32'h0);
        cyc(); #1; chk("h8_vld", 32'(bus.instr_valid), 32'h0);
        cyc(); #1; chk_out("h9", 11'h000, 16'h78A1);
`else
        chk("nohalt", 32'(bus.halted), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
